// File: rtl/p_encoder_pkg.sv
// p_encoder_pkg: shared constants and helpers for the priority encoder slice.
//   P_ENC_DEFAULT_N : default number of request lines.
//   clog2_min1(n)   : index width for n lines, never less than 1 bit.
package p_encoder_pkg;

   localparam int P_ENC_DEFAULT_N = 4;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/p_encoder_core.sv
// p_encoder_core: combinational priority encoder.
//   y          in  [N-1:0] request lines
//   idx        out [W-1:0] index of winning request (0 when none)
//   any        out         at least one request set
//   grant_comb out [N-1:0] one-hot of idx when any (only with P_ENCODER_4TO2_ONEHOT_EN)
// MSB_PRIORITY=1: highest set bit wins; 0: lowest set bit wins.
module p_encoder_core
   import p_encoder_pkg::*;
#(
   parameter int N            = P_ENC_DEFAULT_N,
   parameter int MSB_PRIORITY = 1,
   localparam int W           = clog2_min1(N)
) (
   input  logic [N-1:0] y,
   output logic [W-1:0] idx,
   output logic         any
`ifdef P_ENCODER_4TO2_ONEHOT_EN
   ,
   output logic [N-1:0] grant_comb
`endif
);

   // Scan in rising priority order so the last known-1 bit seen wins; an X
   // on a lower-priority bit cannot disturb the result once a higher one is 1.
   always_comb begin
      idx = '0;
      if (MSB_PRIORITY != 0) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (y[i] == 1'b1) idx = W'(i);
         end
      end else begin
         for (int unsigned i = N; i > 0; i--) begin
            if (y[i-1] == 1'b1) idx = W'(i - 1);
         end
      end
   end

   assign any = |y;

`ifdef P_ENCODER_4TO2_ONEHOT_EN
   always_comb begin
      grant_comb = '0;
      if (any) grant_comb[idx] = 1'b1;
   end
`endif

endmodule

// File: rtl/p_encoder_4to2.sv
// p_encoder_4to2: priority encoder with one registered output stage.
//   clk   in          rising-edge clock
//   rst   in          asynchronous active-high reset
//   en    in          capture enable; outputs hold when low
//   y     in  [N-1:0] request lines
//   a     out [W-1:0] registered winning index (0 when valid=0)
//   valid out         registered "any request set"
//   grant out [N-1:0] registered one-hot of a (only with P_ENCODER_4TO2_ONEHOT_EN)
// Optional feature macro: P_ENCODER_4TO2_ONEHOT_EN.
module p_encoder_4to2
   import p_encoder_pkg::*;
#(
   parameter int N            = P_ENC_DEFAULT_N,
   parameter int MSB_PRIORITY = 1,
   localparam int W           = clog2_min1(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] y,
   output logic [W-1:0] a,
   output logic         valid
`ifdef P_ENCODER_4TO2_ONEHOT_EN
   ,
   output logic [N-1:0] grant
`endif
);

   logic [W-1:0] w_idx;
   logic         w_any;
   logic [W-1:0] r_a;
   logic         r_valid;

`ifdef P_ENCODER_4TO2_ONEHOT_EN
   logic [N-1:0] w_grant;
   logic [N-1:0] r_grant;
`endif

   p_encoder_core #(
      .N            (N),
      .MSB_PRIORITY (MSB_PRIORITY)
   ) u_core (
      .y          (y),
      .idx        (w_idx),
      .any        (w_any)
`ifdef P_ENCODER_4TO2_ONEHOT_EN
      ,
      .grant_comb (w_grant)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_valid <= 1'b0;
`ifdef P_ENCODER_4TO2_ONEHOT_EN
         r_grant <= '0;
`endif
      end else if (en) begin
         r_a     <= w_idx;
         r_valid <= w_any;
`ifdef P_ENCODER_4TO2_ONEHOT_EN
         r_grant <= w_grant;
`endif
      end
   end

   assign a     = r_a;
   assign valid = r_valid;
`ifdef P_ENCODER_4TO2_ONEHOT_EN
   assign grant = r_grant;
`endif

endmodule

// File: tb/tb_p_encoder_4to2.sv
// tb_p_encoder_4to2: self-checking bench for p_encoder_4to2.
// Two instances share stimulus: u_msb (MSB_PRIORITY=1) and u_lsb (MSB_PRIORITY=0).
// Expected outputs are pushed to a scoreboard queue when stimulus is driven and
// popped after the capturing clock edge.
module tb_p_encoder_4to2;

   typedef struct packed {
      logic [1:0] a_m;
      logic       v_m;
      logic [3:0] g_m;
      logic [1:0] a_l;
      logic       v_l;
      logic [3:0] g_l;
   } obs_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] y;
   logic [1:0] a_m, a_l;
   logic       v_m, v_l;
`ifdef P_ENCODER_4TO2_ONEHOT_EN
   logic [3:0] g_m, g_l;
`endif

   int   n_tests;
   int   n_fail;
   obs_t m;
   obs_t sb[$];

   p_encoder_4to2 #(.N(4), .MSB_PRIORITY(1)) u_msb (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .y     (y),
      .a     (a_m),
      .valid (v_m)
`ifdef P_ENCODER_4TO2_ONEHOT_EN
      ,
      .grant (g_m)
`endif
   );

   p_encoder_4to2 #(.N(4), .MSB_PRIORITY(0)) u_lsb (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .y     (y),
      .a     (a_l),
      .valid (v_l)
`ifdef P_ENCODER_4TO2_ONEHOT_EN
      ,
      .grant (g_l)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: search from the winning end, return {any, idx}.
   function automatic logic [2:0] ref_enc(input logic [3:0] v, input bit msb);
      if (msb) begin
         for (int k = 3; k >= 0; k--) if (v[k]) return {1'b1, 2'(k)};
      end else begin
         for (int k = 0; k < 4; k++) if (v[k]) return {1'b1, 2'(k)};
      end
      return 3'b000;
   endfunction

   function automatic obs_t ref_obs(input logic [3:0] v);
      obs_t       r;
      logic [2:0] e;
      e     = ref_enc(v, 1'b1);
      r.a_m = e[1:0];
      r.v_m = e[2];
      r.g_m = e[2] ? (4'b0001 << e[1:0]) : 4'b0000;
      e     = ref_enc(v, 1'b0);
      r.a_l = e[1:0];
      r.v_l = e[2];
      r.g_l = e[2] ? (4'b0001 << e[1:0]) : 4'b0000;
`ifndef P_ENCODER_4TO2_ONEHOT_EN
      r.g_m = '0;
      r.g_l = '0;
`endif
      return r;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.a_m = a_m;
      o.v_m = v_m;
      o.a_l = a_l;
      o.v_l = v_l;
`ifdef P_ENCODER_4TO2_ONEHOT_EN
      o.g_m = g_m;
      o.g_l = g_l;
`else
      o.g_m = '0;
      o.g_l = '0;
`endif
      return o;
   endfunction

   // Drive one cycle of stimulus, push the expected capture, advance past the edge.
   task automatic step(input logic [3:0] yv, input logic env);
      y  = yv;
      en = env;
      if (env) m = ref_obs(yv);
      sb.push_back(m);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t o;
      rst = 1'b0;
      en  = 1'b1;
      y   = 4'b1111;
      #1 rst = 1'b1;
      #1;
      o = dut_obs();
      n_tests++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got %h expected %h", o, obs_t'('0));
      end
      @(posedge clk);
      #1;
      o = dut_obs();
      n_tests++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL reset_held_over_edge: got %h expected %h", o, obs_t'('0));
      end
      rst = 1'b0;
      m   = '0;
      step(4'b1111, 1'b1);
      o = dut_obs();
      n_tests++;
      if (o !== sb.pop_front()) begin
         n_fail++;
         $display("FAIL reset_release: got %h expected %h", o, m);
      end
   endtask

   task automatic test_ladder();
      logic [3:0] tbl[4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      obs_t o, e;
      foreach (tbl[i]) begin
         step(tbl[i], 1'b1);
         o = dut_obs();
         e = sb.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL ladder[%0d] y=%b: got %h expected %h", i, tbl[i], o, e);
         end
      end
   endtask

   task automatic test_empty_single();
      logic [3:0] tbl[3] = '{4'b0000, 4'b0100, 4'b1000};
      obs_t o, e;
      foreach (tbl[i]) begin
         step(tbl[i], 1'b1);
         o = dut_obs();
         e = sb.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL empty_single[%0d] y=%b: got %h expected %h", i, tbl[i], o, e);
         end
      end
   endtask

   task automatic test_enable_hold();
      logic [3:0] ytbl[5]  = '{4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
      logic       entbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      obs_t o, e;
      foreach (ytbl[i]) begin
         step(ytbl[i], entbl[i]);
         o = dut_obs();
         e = sb.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL enable_hold[%0d] y=%b en=%b: got %h expected %h",
                     i, ytbl[i], entbl[i], o, e);
         end
      end
   endtask

   task automatic test_lsb_priority();
      logic [3:0] tbl[2] = '{4'b0110, 4'b1000};
      obs_t o, e;
      foreach (tbl[i]) begin
         step(tbl[i], 1'b1);
         o = dut_obs();
         e = sb.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL lsb_priority[%0d] y=%b: got %h expected %h", i, tbl[i], o, e);
         end
      end
   endtask

   task automatic test_midrun_reset();
      obs_t o, e;
      step(4'b0100, 1'b1);
      o = dut_obs();
      e = sb.pop_front();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL midrun_pre: got %h expected %h", o, e);
      end
      rst = 1'b1;
      #1;
      o = dut_obs();
      n_tests++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL midrun_async_clear: got %h expected %h", o, obs_t'('0));
      end
      #3 rst = 1'b0;
      m = '0;
      #1;
      o = dut_obs();
      n_tests++;
      if (o !== '0) begin
         n_fail++;
         $display("FAIL midrun_after_release: got %h expected %h", o, obs_t'('0));
      end
      step(4'b0100, 1'b1);
      o = dut_obs();
      e = sb.pop_front();
      n_tests++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL midrun_recapture: got %h expected %h", o, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] yv;
      logic       ev;
      obs_t o, e;
      for (int i = 0; i < 40; i++) begin
         yv = 4'($urandom_range(0, 15));
         ev = ($urandom_range(0, 3) != 0);
         step(yv, ev);
         o = dut_obs();
         e = sb.pop_front();
         n_tests++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] y=%b en=%b: got %h expected %h", i, yv, ev, o, e);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      m       = '0;
      test_reset();
      test_ladder();
      test_empty_single();
      test_enable_hold();
      test_lsb_priority();
      test_midrun_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
